// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier: round-to-nearest-even, flush-to-zero denormals,
// special-value handling, exception flags and valid/ready backpressure on a single stall enable.
module fp_mul_pipe #(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    localparam int FP_W  = 1 + EXP_W + MAN_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [FP_W-1:0] in_a,
    input  logic [FP_W-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FP_W-1:0] out_res,
    output logic [3:0]      out_flags
);

    localparam int EW2     = EXP_W + 2;
    localparam int PW      = 2 * MAN_W + 2;
    localparam int BIAS    = 2 ** (EXP_W - 1) - 1;
    localparam int EXP_MAX = 2 ** EXP_W - 1;
    localparam logic [FP_W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {
        K_NORM = 2'd0,
        K_ZERO = 2'd1,
        K_INF  = 2'd2,
        K_NAN  = 2'd3
    } kind_t;

    logic en;

    // stage 1 registers
    logic             s1_valid_q;
    logic             s1_sign_q,  s1_sign_d;
    kind_t            s1_kind_q,  s1_kind_d;
    logic             s1_inv_q,   s1_inv_d;
    logic [EW2-1:0]   s1_exp_q,   s1_exp_d;
    logic [MAN_W:0]   s1_ma_q,    s1_ma_d;
    logic [MAN_W:0]   s1_mb_q,    s1_mb_d;

    // stage 2 registers
    logic             s2_valid_q;
    logic             s2_sign_q;
    kind_t            s2_kind_q;
    logic             s2_inv_q;
    logic [EW2-1:0]   s2_exp_q;
    logic [PW-1:0]    s2_prod_q, s2_prod_d;

    // stage 3 (output) registers
    logic             out_valid_q;
    logic [FP_W-1:0]  out_res_q,   out_res_d;
    logic [3:0]       out_flags_q, out_flags_d;

    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;

    // ---------------- stage 1: unpack and classify ----------------
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan, inf_x_zero;

    assign ea = in_a[FP_W-2 -: EXP_W];
    assign eb = in_b[FP_W-2 -: EXP_W];
    assign fa = in_a[MAN_W-1:0];
    assign fb = in_b[MAN_W-1:0];

    // exponent field zero covers true zeros and flushed denormals alike
    assign a_zero = ~|ea;
    assign b_zero = ~|eb;
    assign a_inf  = (&ea) && ~|fa;
    assign b_inf  = (&eb) && ~|fb;
    assign a_nan  = (&ea) && |fa;
    assign b_nan  = (&eb) && |fb;
    assign a_snan = a_nan && !fa[MAN_W-1];
    assign b_snan = b_nan && !fb[MAN_W-1];
    assign inf_x_zero = (a_inf && b_zero) || (b_inf && a_zero);

    always_comb begin
        s1_kind_d = K_NORM;
        s1_inv_d  = 1'b0;
        if (a_nan || b_nan || inf_x_zero) begin
            s1_kind_d = K_NAN;
            s1_inv_d  = a_snan || b_snan || inf_x_zero;
        end else if (a_inf || b_inf) begin
            s1_kind_d = K_INF;
        end else if (a_zero || b_zero) begin
            s1_kind_d = K_ZERO;
        end
    end

    assign s1_sign_d = in_a[FP_W-1] ^ in_b[FP_W-1];
    assign s1_exp_d  = {2'b00, ea} + {2'b00, eb} - EW2'(BIAS);
    assign s1_ma_d   = {1'b1, fa};
    assign s1_mb_d   = {1'b1, fb};

    // ---------------- stage 2: mantissa product ----------------
    assign s2_prod_d = PW'(s1_ma_q) * PW'(s1_mb_q);

    // ---------------- stage 3: normalise, round, range check, pack ----------------
    logic             msb;
    logic [PW-2:0]    norm;
    logic [MAN_W-1:0] frac, frac_r;
    logic             guard, rnd, sticky, round_up, carry;
    logic [EW2-1:0]   exp_r;
    logic             ovf, unf;

    assign msb      = s2_prod_q[PW-1];
    // drop the leading one; the bit below it becomes the fraction MSB
    assign norm     = msb ? s2_prod_q[PW-2:0] : {s2_prod_q[PW-3:0], 1'b0};
    assign frac     = norm[PW-2 -: MAN_W];
    assign guard    = norm[MAN_W];
    assign rnd      = norm[MAN_W-1];
    assign sticky   = |norm[MAN_W-2:0];
    assign round_up = guard && (rnd || sticky || frac[0]);
    assign {carry, frac_r} = {1'b0, frac} + (MAN_W+1)'(round_up);
    assign exp_r    = s2_exp_q + EW2'(msb) + EW2'(carry);
    assign ovf      = !exp_r[EW2-1] && (exp_r[EW2-2:0] >= (EW2-1)'(EXP_MAX));
    assign unf      = exp_r[EW2-1] || (exp_r == '0);

    always_comb begin
        out_res_d   = {s2_sign_q, exp_r[EXP_W-1:0], frac_r};
        out_flags_d = {3'b000, guard || rnd || sticky};
        case (s2_kind_q)
            K_NAN: begin
                out_res_d   = QNAN;
                out_flags_d = {s2_inv_q, 3'b000};
            end
            K_INF: begin
                out_res_d   = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                out_flags_d = 4'b0000;
            end
            K_ZERO: begin
                out_res_d   = {s2_sign_q, {(FP_W-1){1'b0}}};
                out_flags_d = 4'b0000;
            end
            default: begin
                if (ovf) begin
                    out_res_d   = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    out_flags_d = 4'b0101;
                end else if (unf) begin
                    out_res_d   = {s2_sign_q, {(FP_W-1){1'b0}}};
                    out_flags_d = 4'b0011;
                end
            end
        endcase
    end

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_kind_q   <= K_NORM;
            s1_inv_q    <= 1'b0;
            s1_exp_q    <= '0;
            s1_ma_q     <= '0;
            s1_mb_q     <= '0;
            s2_valid_q  <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_kind_q   <= K_NORM;
            s2_inv_q    <= 1'b0;
            s2_exp_q    <= '0;
            s2_prod_q   <= '0;
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
            out_flags_q <= '0;
        end else if (en) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_sign_q <= s1_sign_d;
                s1_kind_q <= s1_kind_d;
                s1_inv_q  <= s1_inv_d;
                s1_exp_q  <= s1_exp_d;
                s1_ma_q   <= s1_ma_d;
                s1_mb_q   <= s1_mb_d;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_sign_q <= s1_sign_q;
                s2_kind_q <= s1_kind_q;
                s2_inv_q  <= s1_inv_q;
                s2_exp_q  <= s1_exp_q;
                s2_prod_q <= s2_prod_d;
            end
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                out_res_q   <= out_res_d;
                out_flags_q <= out_flags_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_res   = out_res_q;
    assign out_flags = out_flags_q;

endmodule
